// File: rtl/icache_direct_mapped_if.sv
// Memory-side line-fill bus for icache_direct_mapped.
// master: the cache (issues mem_req_o/mem_addr_o, receives ready and data beats).
// slave:  the memory / next level (accepts requests, returns beats in ascending word order).
interface icache_direct_mapped_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped L1 instruction cache feeding the fetch stage.
// Lookup of pc_f_i is combinational (instr_f_o / instr_hit_f_o in the same cycle);
// a miss starts a line refill over the mem bus (request, then WORDS_PER_LINE beats),
// after which the whole line, its tag and valid bit are installed in one UPDATE cycle.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   pc_f_i               fetch PC (bits [1:0] ignored)
//   instr_f_o            instruction on hit, NOP_INSTR otherwise
//   instr_hit_f_o        lookup hit this cycle
//   ic_repl_permit_o     high while no refill is in flight
//   mem                  line-fill bus (icache_direct_mapped_if.master)
//   hit_count_o, miss_count_o   saturating perf counters, only with ICACHE_PERF_CNT_EN
// Optional feature macro: ICACHE_PERF_CNT_EN.
module icache_direct_mapped #(
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] pc_f_i,
    output logic [31:0] instr_f_o,
    output logic        instr_hit_f_o,
    output logic        ic_repl_permit_o,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o,
`endif
    icache_direct_mapped_if.master mem
);
    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned IDX_LSB = OFF_W + 2;
    localparam int unsigned TAG_W   = 32 - IDX_LSB - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_UPDATE
    } state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0]                 valid_q;
    logic [TAG_W-1:0]                     tag_q   [NUM_LINES];
    logic [WORDS_PER_LINE-1:0][31:0]      data_q  [NUM_LINES];
    logic [WORDS_PER_LINE-1:0][31:0]      fill_buf_q;
    logic [OFF_W-1:0]                     beat_q, beat_d;
    logic [31:0]                          line_addr_q, line_addr_d;
    logic                                 mem_req_q;
    logic                                 permit_q;

    logic [OFF_W-1:0] pc_off_c;
    logic [IDX_W-1:0] pc_idx_c;
    logic [TAG_W-1:0] pc_tag_c;
    logic [IDX_W-1:0] fill_idx_c;
    logic [TAG_W-1:0] fill_tag_c;
    logic             hit_c;
    logic             miss_c;
    logic             beat_wr_c;
    logic             unused_pc_c;

    // Address split of the fetch PC and of the latched refill line address
    assign pc_off_c    = pc_f_i[2 +: OFF_W];
    assign pc_idx_c    = pc_f_i[IDX_LSB +: IDX_W];
    assign pc_tag_c    = pc_f_i[31 -: TAG_W];
    assign fill_idx_c  = line_addr_q[IDX_LSB +: IDX_W];
    assign fill_tag_c  = line_addr_q[31 -: TAG_W];
    assign unused_pc_c = ^pc_f_i[1:0];

    // Lookup is only honoured while idle so a half-built line is never returned
    assign hit_c = valid_q[pc_idx_c] && (tag_q[pc_idx_c] == pc_tag_c) && (state_q == S_IDLE);

    assign instr_f_o        = hit_c ? data_q[pc_idx_c][pc_off_c] : NOP_INSTR;
    assign instr_hit_f_o    = hit_c;
    assign ic_repl_permit_o = permit_q;
    assign mem.mem_req_o    = mem_req_q;
    assign mem.mem_addr_o   = line_addr_q;

    // Refill sequencing: next state, beat counter and line-address latch
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        miss_c      = 1'b0;
        beat_wr_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit_c) begin
                    miss_c      = 1'b1;
                    line_addr_d = {pc_f_i[31:IDX_LSB], IDX_LSB'(0)};
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ready_i) begin
                    beat_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem.mem_rvalid_i) begin
                    beat_wr_c = 1'b1;
                    beat_d    = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, control outputs and valid bits (outputs derived from next state to stay glitch-free)
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            permit_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            mem_req_q   <= (state_d == S_REQ);
            permit_q    <= (state_d == S_IDLE);
            if (state_q == S_UPDATE) begin
                valid_q[fill_idx_c] <= 1'b1;
            end
        end
    end

    // Fill buffer and line storage; contents are qualified by valid_q so need no reset
    always_ff @(posedge clk_i) begin
        if (beat_wr_c) begin
            fill_buf_q[beat_q] <= mem.mem_rdata_i;
        end
        if (state_q == S_UPDATE) begin
            tag_q[fill_idx_c]  <= fill_tag_c;
            data_q[fill_idx_c] <= fill_buf_q;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit / miss counters
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomized scoreboard bench for icache_direct_mapped (default parameters).
// The driver plays fetch stage and memory, predicts each cycle's outputs from a
// line-granular cache model and queues them; the monitor compares at the falling edge.
module tb_icache_direct_mapped;
    localparam int unsigned NL     = 64;
    localparam int unsigned WPL    = 4;
    localparam int unsigned LINE_B = WPL * 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_FILL = 2;
    localparam int P_UPD  = 3;

    logic        clk;
    logic        reset_n_i;
    logic [31:0] pc_f_i;
    logic [31:0] instr_f_o;
    logic        instr_hit_f_o;
    logic        ic_repl_permit_o;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    icache_direct_mapped_if mem_if ();

    icache_direct_mapped dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .pc_f_i           (pc_f_i),
        .instr_f_o        (instr_f_o),
        .instr_hit_f_o    (instr_hit_f_o),
        .ic_repl_permit_o (ic_repl_permit_o),
`ifdef ICACHE_PERF_CNT_EN
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o),
`endif
        .mem              (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] instr;
        logic        permit;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: which memory line each index holds, plus its words
    bit          m_valid [NL];
    int unsigned m_line  [NL];
    logic [31:0] m_data  [NL][WPL];
    int          ph = P_IDLE;
    logic [31:0] fill_addr;
    int          wait_cnt;
    int          next_wait = -1;
    int          beat;
    logic [31:0] fbuf [WPL];
    logic [31:0] fill_data_q[$];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;
    bit          last_hit;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic bit m_lookup(input logic [31:0] pc, output logic [31:0] w);
        int unsigned ln;
        int unsigned idx;
        ln  = pc / LINE_B;
        idx = ln % NL;
        w   = m_data[idx][(pc % LINE_B) / 4];
        return m_valid[idx] && (m_line[idx] == ln);
    endfunction

    function automatic logic [31:0] next_beat();
        if (fill_data_q.size() > 0) return fill_data_q.pop_front();
        return $urandom;
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, advance the model
    task automatic step(input logic [31:0] pc);
        exp_t        e;
        logic [31:0] w;
        int unsigned idx;
        pc_f_i              = pc;
        mem_if.mem_ready_i  = 1'b0;
        mem_if.mem_rvalid_i = ($urandom_range(0, 3) == 0);
        mem_if.mem_rdata_i  = $urandom;
        e = '{hit: 1'b0, instr: NOP, permit: 1'b0, req: 1'b0, chk_addr: 1'b0, addr: 32'h0};
        last_hit = 1'b0;
        case (ph)
            P_IDLE: begin
                e.permit = 1'b1;
                if (m_lookup(pc, w)) begin
                    e.hit    = 1'b1;
                    e.instr  = w;
                    last_hit = 1'b1;
                    m_hits++;
                end else begin
                    m_misses++;
                    fill_addr = (pc / LINE_B) * LINE_B;
                    wait_cnt  = (next_wait >= 0) ? next_wait : int'($urandom_range(0, 3));
                    next_wait = -1;
                    ph        = P_REQ;
                end
            end
            P_REQ: begin
                e.req      = 1'b1;
                e.chk_addr = 1'b1;
                e.addr     = fill_addr;
                if (wait_cnt == 0) begin
                    mem_if.mem_ready_i = 1'b1;
                    beat = 0;
                    ph   = P_FILL;
                end else begin
                    wait_cnt--;
                end
            end
            P_FILL: begin
                mem_if.mem_rvalid_i = ($urandom_range(0, 2) != 0);
                if (mem_if.mem_rvalid_i) begin
                    mem_if.mem_rdata_i = next_beat();
                    fbuf[beat] = mem_if.mem_rdata_i;
                    beat++;
                    if (beat == WPL) ph = P_UPD;
                end
            end
            default: begin
                idx = (fill_addr / LINE_B) % NL;
                m_valid[idx] = 1'b1;
                m_line[idx]  = fill_addr / LINE_B;
                for (int i = 0; i < WPL; i++) m_data[idx][i] = fbuf[i];
                ph = P_IDLE;
            end
        endcase
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles with stray beats on the bus; model forgets all lines
    task automatic do_reset(input int n);
        exp_t e;
        reset_n_i = 1'b0;
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        ph = P_IDLE;
        next_wait = -1;
        fill_data_q.delete();
        m_hits = 0;
        m_misses = 0;
        for (int c = 0; c < n; c++) begin
            pc_f_i              = $urandom;
            mem_if.mem_ready_i  = 1'($urandom_range(0, 1));
            mem_if.mem_rvalid_i = 1'b1;
            mem_if.mem_rdata_i  = $urandom;
            e = '{hit: 1'b0, instr: NOP, permit: 1'b1, req: 1'b0, chk_addr: 1'b1, addr: 32'h0};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        reset_n_i = 1'b1;
    endtask

    // Keep fetching pc until the model predicts a hit
    task automatic go(input logic [31:0] pc);
        for (int i = 0; i < 60; i++) begin
            step(pc);
            if (last_hit) return;
        end
        fails++;
        $display("FAIL go_timeout pc=%h actual=no_hit expected=hit", pc);
    endtask

    task automatic perf_check();
`ifdef ICACHE_PERF_CNT_EN
        check("hit_count", hit_count_o, m_hits);
        check("miss_count", miss_count_o, m_misses);
`endif
    endtask

    // Monitor: the DUT presents a lookup result every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hit", 32'(instr_hit_f_o), 32'(e.hit));
                check("instr", instr_f_o, e.instr);
                check("permit", 32'(ic_repl_permit_o), 32'(e.permit));
                check("mem_req", 32'(mem_if.mem_req_o), 32'(e.req));
                if (e.chk_addr) check("mem_addr", mem_if.mem_addr_o, e.addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc;
        reset_n_i           = 1'b0;
        pc_f_i              = 32'h0;
        mem_if.mem_ready_i  = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = 32'h0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Cold miss with directed beats and a two-cycle ready wait
        for (int i = 0; i < WPL; i++) fill_data_q.push_back(32'hA0 + 32'(i));
        next_wait = 2;
        go(32'h100);
        step(32'h104);
        step(32'h108);
        step(32'h10C);
        perf_check();

        // Conflict eviction on index 16
        for (int i = 0; i < WPL; i++) fill_data_q.push_back(32'hB0 + 32'(i));
        go(32'h500);
        go(32'h100);

        // Reset after beat 1 of a fill
        for (int i = 0; i < 60 && !(ph == P_FILL && beat == 2); i++) step(32'h240);
        do_reset(2);
        go(32'h100);

        // Redirect during fill
        for (int i = 0; i < 60 && ph != P_FILL; i++) step(32'h200);
        for (int i = 0; i < 60 && ph != P_IDLE; i++) step(32'h300);
        go(32'h300);
        go(32'h200);
        perf_check();

        // Random traffic over a few conflicting lines, with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1 + int'($urandom_range(0, 1)));
            pc = (($urandom_range(0, 3) * NL + $urandom_range(0, 3)) * LINE_B)
                 + $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3);
            step(pc);
        end
        for (int i = 0; i < 60 && ph != P_IDLE; i++) step(32'h0);
        perf_check();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped L1 instruction cache. Sits directly upstream of the pipelined core's fetch stage.
- Looks up pc_f_i combinationally and returns instruction plus hit flag in the same cycle.
- On a miss, a refill FSM fetches one full line from the memory side over a request/beat handshake, then installs it.
- Also provides the replacement-permit signal used by the hazard unit.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, value driven on instr_f_o when not hitting.

Ports:
- clk_i  input  1  clock.
- reset_n_i  input  1  reset; asynchronous, active-low.
- pc_f_i  input  32  fetch PC; bits [1:0] ignored.
- instr_f_o  output  32  fetched instruction; valid when instr_hit_f_o=1.
- instr_hit_f_o  output  1  lookup hit this cycle.
- ic_repl_permit_o  output  1  high when cache is IDLE (no refill in flight).
- mem_req_o  output  1  line-fill request.
- mem_addr_o  output  32  line-aligned fill address.
- mem_ready_i  input  1  memory accepts request (handshake: mem_req_o & mem_ready_i).
- mem_rvalid_i  input  1  fill data beat valid.
- mem_rdata_i  input  32  fill data beat, ascending word order.

Behaviour:
- Address split:
  - offset = pc[log2(WPL)+1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage: data array, tag array and one valid bit per line.
- Lookup is combinational: hit = valid[index] & tag match & state==IDLE.
  - Hit: instr_f_o = data[index][offset].
  - Otherwise instr_f_o = NOP_INSTR.
- FSM:
  - IDLE: on a miss, latch the line address {tag,index,0} and go to REQ.
  - REQ: mem_req_o=1, mem_addr_o = latched address, held stable until mem_ready_i. On handshake go to FILL and clear beat counter.
  - FILL: each mem_rvalid_i writes mem_rdata_i into a fill buffer at the beat counter and increments the counter. On beat WORDS_PER_LINE-1 go to UPDATE.
  - UPDATE: write buffer, tag and valid=1 into the latched index; go to IDLE. instr_hit_f_o=0 this cycle.
- Miss latency: lookup resumes in the cycle after UPDATE.
  - Total = 1 (REQ min) + ready wait + WORDS_PER_LINE beats + 1.
- pc_f_i changes during REQ/FILL (redirect): the refill for the latched address completes regardless. After UPDATE, lookup uses the current pc_f_i.
- mem_rvalid_i outside FILL: ignored.
- mem_rdata_i gaps: the counter advances only on rvalid.
- Replacement: unconditional overwrite of the indexed line.
- Reset (any time, including mid-fill):
  - FSM → IDLE; beat counter 0; all valid bits 0.
  - mem_req_o=0, mem_addr_o=0, instr_hit_f_o=0, instr_f_o=NOP_INSTR, ic_repl_permit_o=1.
  - Beats arriving after reset are ignored. Tag and data arrays are not reset.
- ic_repl_permit_o = (state==IDLE), registered-state derived, glitch-free.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined: adds ports hit_count_o (output, 32) and miss_count_o (output, 32).
  - hit_count_o increments each IDLE cycle with hit.
  - miss_count_o increments once per IDLE→REQ transition.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Cold miss: after reset, pc_f_i=0x100 → hit=0, instr=0x13.
  - mem_req_o=1 with mem_addr_o=0x100; ready after 2 cycles.
  - Beats 0xA0,0xA1,0xA2,0xA3 → UPDATE, then next cycle hit=1 and instr=0xA0.
- Same-line hits: pc 0x104/0x108/0x10C → hit=1 same cycle with 0xA1/0xA2/0xA3; no mem_req_o.
- Conflict eviction (defaults): fill 0x100, then pc=0x500 (same index 16) → miss, refill with 0xB0..0xB3 → hit 0xB0. Then pc=0x100 misses again with mem_addr_o=0x100.
- Reset mid-fill: assert reset_n_i=0 after beat 1 of a fill → mem_req_o=0, FSM IDLE, ic_repl_permit_o=1.
  - Post-reset pc=0x100 misses even though 0x100 was filled earlier.
  - Stray rvalid beats are ignored.
- Redirect mid-fill: miss at 0x200, switch pc_f_i to 0x300 during FILL → line 0x200 is installed. Then 0x300 misses with mem_addr_o=0x300. Return to 0x200 → hit.
- Perf counters (ICACHE_PERF_CNT_EN): cold miss + 3 hits → miss_count_o=1, hit_count_o=4, counting the hit at 0x100 after fill.
